stall_flush_ctrl: RTL and testbench
===================================

Name: stall_flush_ctrl

Overview:
Pipeline interlock controller for the 5-stage integer pipeline. It sequences the PC, IF/ID, ID/EX and EX/MEM latches for three cases:
- a one-cycle load-use stall;
- a multi-cycle multiply held in EX;
- an IF/ID flush on a taken branch or jump resolved in EX.

It sits beside the forwarding logic and drives the latch enable/bubble controls.

Parameters:
MUL_LAT, 4, total EX-stage cycles of a multiply (legal 1..16)
CNT_W, 4, width of the multiply cycle counter (must satisfy 2^CNT_W >= MUL_LAT)

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
rs1_id  in  5  ID-stage source register 1
rs2_id  in  5  ID-stage source register 2
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2 (R-type or store data)
memRead_ex  in  1  EX instruction is a load
rd_ex  in  5  EX instruction destination register
mul_ex  in  1  EX instruction is a multiply
taken_ex  in  1  branch/jump in EX resolved taken
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID latch
stall_idex  out  1  hold ID/EX latch
bubble_idex  out  1  load a NOP into ID/EX
bubble_exmem  out  1  load a NOP into EX/MEM
flush_ifid  out  1  load a NOP into IF/ID
mul_done  out  1  multiply result valid in EX this cycle
stall_cycles  out  32  performance counter of stalled cycles (see Optional Feature)

Behaviour:
- States: RUN, MUL_BUSY. Counter cnt[CNT_W-1:0].
- Reset: state=RUN, cnt=0. While reset is high, all outputs are forced to 0, and stall_cycles is cleared.
- Load-use hazard, lu:
  - Condition: memRead_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
  - Response (combinational, same cycle): stall_pc=stall_ifid=1, bubble_idex=1.
  - Exactly one stall cycle results, because the load advances to MEM.
- Multiply:
  - RUN & mul_ex & MUL_LAT==1: mul_done=1, no stall.
  - RUN & mul_ex & MUL_LAT>1: stall_pc=stall_ifid=stall_idex=1, bubble_exmem=1; cnt<=MUL_LAT-2; next state=MUL_BUSY.
  - MUL_BUSY & cnt!=0: same four outputs asserted; cnt<=cnt-1.
  - MUL_BUSY & cnt==0: no stall; mul_done=1; next state=RUN.
  - Total stall cycles = MUL_LAT-1. mul_done pulses for exactly one cycle per multiply.
- mul_ex is ignored in MUL_BUSY, because the same multiply is held in EX.
- Flush: taken_ex in RUN drives flush_ifid=1 combinationally. PC is not stalled.
- Priority: taken_ex suppresses lu, since the ID instruction is being discarded. lu and mul_ex cannot both be true because EX holds one instruction; if both are seen anyway, mul_ex wins.
- rd_ex==0 never produces a stall (r0 is hardwired).
- Outputs are combinational from state and inputs; only state, cnt and stall_cycles are registered.
- Reset mid-multiply: state returns to RUN at the clock edge. The first cycle after reset deasserts all stalls unless new inputs demand them.

Optional Feature:
STALL_COUNT_EN.
- Defined: stall_cycles increments by 1 on every clock where stall_pc=1. It saturates at 0xFFFFFFFF and clears on reset.
- Undefined: stall_cycles is tied to 0 and no counter register is built. The port list is unchanged.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding constants RUN=0, MUL_BUSY=1;
  - REG_ZERO=5'd0;
  - default MUL_LAT.
- One sub-module, reg_match: 5-bit equality with a use-enable and an r0 exclusion. Instantiated twice, for rs1 and rs2 against rd_ex.

Test Plan:
- Load-use: memRead_ex=1, rd_ex=7, rs2_id=7, rs2_used_id=1 for one cycle -> stall_pc, stall_ifid and bubble_idex are 1 that cycle only; 0 the next cycle.
- r0 exclusion: memRead_ex=1, rd_ex=0, rs1_id=0, rs1_used_id=1 -> no stall outputs asserted.
- Multiply, MUL_LAT=4: mul_ex=1 held -> stall outputs high for cycles 0..2, mul_done=1 at cycle 3, state RUN at cycle 4; with the macro defined, stall_cycles=3.
- Branch/load priority: taken_ex=1 with a matching lu condition -> flush_ifid=1, stall_pc=0, bubble_idex=0.
- Reset at multiply cycle 1: reset=1 -> all outputs 0 that cycle; after reset, mul_ex=0 -> no stalls and state RUN.
- MUL_LAT=1 build: mul_ex=1 -> mul_done=1 in the same cycle, no stall or bubble asserted.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline interlock controller: FSM state type,
// the hardwired-zero register index and the default multiply latency.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } ctrl_state_t;

  localparam logic [4:0]  REG_ZERO        = 5'd0;
  localparam int unsigned DEFAULT_MUL_LAT = 4;

endpackage

// File: rtl/reg_match.sv
// Source/destination register comparator for hazard detection.
// It matches only when the source is actually read and the destination is not r0.
module reg_match
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       rs_used,
  input  logic [4:0] rd,
  output logic       match
);

  assign match = rs_used && (rd != REG_ZERO) && (rs == rd);

endmodule

// File: rtl/stall_flush_ctrl.sv
// Pipeline interlock controller: load-use stall, multi-cycle multiply hold, and
// IF/ID flush. Define STALL_COUNT_EN to build the saturating stall_cycles counter.
module stall_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = DEFAULT_MUL_LAT,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic        memRead_ex,
  input  logic [4:0]  rd_ex,
  input  logic        mul_ex,
  input  logic        taken_ex,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        bubble_idex,
  output logic        bubble_exmem,
  output logic        flush_ifid,
  output logic        mul_done,
  output logic [31:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_LOAD = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;

  ctrl_state_t      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             match1, match2, lu;

  reg_match u_match_rs1 (
    .rs      (rs1_id),
    .rs_used (rs1_used_id),
    .rd      (rd_ex),
    .match   (match1)
  );

  reg_match u_match_rs2 (
    .rs      (rs2_id),
    .rs_used (rs2_used_id),
    .rd      (rd_ex),
    .match   (match2)
  );

  assign lu = memRead_ex && (match1 || match2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    stall_idex   = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    flush_ifid   = 1'b0;
    mul_done     = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN: begin
          flush_ifid = taken_ex;
          // Multiply outranks load-use; a taken branch discards the ID
          // instruction, so its load-use hazard is moot.
          if (mul_ex) begin
            if (MUL_LAT == 1) begin
              mul_done = 1'b1;
            end else begin
              stall_pc     = 1'b1;
              stall_ifid   = 1'b1;
              stall_idex   = 1'b1;
              bubble_exmem = 1'b1;
              cnt_next     = CNT_LOAD;
              state_next   = MUL_BUSY;
            end
          end else if (lu && !taken_ex) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end
        end
        MUL_BUSY: begin
          if (cnt != '0) begin
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            bubble_exmem = 1'b1;
            cnt_next     = cnt - CNT_W'(1);
          end else begin
            mul_done   = 1'b1;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

`ifdef STALL_COUNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_pc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = reset ? '0 : stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Scoreboard bench for stall_flush_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them. A MUL_LAT=1 instance is spot-checked too.
module tb_stall_flush_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_id, rs2_id, rd_ex;
  logic        rs1_used_id, rs2_used_id, memRead_ex, mul_ex, taken_ex;

  logic        stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem, flush_ifid, mul_done;
  logic [31:0] stall_cycles;
  logic        stall_pc1, stall_ifid1, stall_idex1, bubble_idex1, bubble_exmem1, flush_ifid1, mul_done1;
  logic [31:0] stall_cycles1;

  always #5 clk = ~clk;

  stall_flush_ctrl #(.MUL_LAT(4), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .memRead_ex(memRead_ex),
    .rd_ex(rd_ex), .mul_ex(mul_ex), .taken_ex(taken_ex),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .bubble_idex(bubble_idex), .bubble_exmem(bubble_exmem), .flush_ifid(flush_ifid),
    .mul_done(mul_done), .stall_cycles(stall_cycles)
  );

  stall_flush_ctrl #(.MUL_LAT(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .memRead_ex(memRead_ex),
    .rd_ex(rd_ex), .mul_ex(mul_ex), .taken_ex(taken_ex),
    .stall_pc(stall_pc1), .stall_ifid(stall_ifid1), .stall_idex(stall_idex1),
    .bubble_idex(bubble_idex1), .bubble_exmem(bubble_exmem1), .flush_ifid(flush_ifid1),
    .mul_done(mul_done1), .stall_cycles(stall_cycles1)
  );

  // Output vector: {stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem, flush_ifid, mul_done}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1101000;
  localparam logic [6:0] O_MUL  = 7'b1110100;
  localparam logic [6:0] O_DONE = 7'b0000001;
  localparam logic [6:0] O_FL   = 7'b0000010;

  typedef struct {
    string       name;
    logic [6:0]  o;
    logic [31:0] sc;
    logic        chk1;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] exp_sc = '0;

  wire [6:0] act  = {stall_pc, stall_ifid, stall_idex, bubble_idex, bubble_exmem, flush_ifid, mul_done};
  wire [6:0] act1 = {stall_pc1, stall_ifid1, stall_idex1, bubble_idex1, bubble_exmem1, flush_ifid1, mul_done1};

  always @(negedge clk) begin
    exp_t t;
    if (sb.size() > 0) begin
      t = sb.pop_front();
      checks++;
      if (act !== t.o) begin
        errors++;
        $display("FAIL %s outputs: got %b expected %b", t.name, act, t.o);
      end
      checks++;
      if (stall_cycles !== t.sc) begin
        errors++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", t.name, stall_cycles, t.sc);
      end
      if (t.chk1) begin
        checks++;
        if (act1 !== O_DONE) begin
          errors++;
          $display("FAIL %s lat1 outputs: got %b expected %b", t.name, act1, O_DONE);
        end
      end
    end
  end

  task automatic drv(input logic rst, input logic mr, input logic [4:0] rd,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                     input logic u2, input logic mul, input logic tk);
    reset = rst; memRead_ex = mr; rd_ex = rd;
    rs1_id = r1; rs1_used_id = u1; rs2_id = r2; rs2_used_id = u2;
    mul_ex = mul; taken_ex = tk;
  endtask

  task automatic step(input string nm, input logic [6:0] e, input logic c1);
    exp_t t;
    t.name = nm;
    t.o    = e;
    t.chk1 = c1;
`ifdef STALL_COUNT_EN
    t.sc   = reset ? 32'd0 : exp_sc;
`else
    t.sc   = 32'd0;
`endif
    sb.push_back(t);
    @(negedge clk);
    @(posedge clk);
    if (reset) exp_sc = '0;
    else if (e[6]) exp_sc = exp_sc + 32'd1;
    #1;
  endtask

  initial begin
    drv(1, 1, 5'd7, 5'd7, 1, 5'd7, 1, 0, 0); step("reset0", O_NONE, 0);
    drv(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1); step("reset1", O_NONE, 0);
    drv(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0); step("idle", O_NONE, 0);
    drv(0, 1, 5'd7, 5'd3, 1, 5'd7, 1, 0, 0); step("lu_rs2", O_LU, 0);
    drv(0, 0, 5'd0, 5'd3, 1, 5'd7, 1, 0, 0); step("lu_after", O_NONE, 0);
    drv(0, 1, 5'd12, 5'd12, 1, 5'd1, 0, 0, 0); step("lu_rs1", O_LU, 0);
    drv(0, 1, 5'd12, 5'd12, 0, 5'd12, 0, 0, 0); step("lu_unused", O_NONE, 0);
    drv(0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0); step("r0_excl", O_NONE, 0);
    drv(0, 0, 5'd9, 5'd9, 1, 5'd9, 1, 0, 0); step("no_load", O_NONE, 0);
    drv(0, 1, 5'd9, 5'd9, 1, 5'd2, 1, 0, 1); step("taken_lu", O_FL, 0);
    drv(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1); step("taken", O_FL, 0);
    // Four-cycle multiply with mul_ex held throughout
    drv(0, 0, 5'd4, 5'd1, 1, 5'd2, 1, 1, 0); step("mul_c0", O_MUL, 1);
    step("mul_c1", O_MUL, 1);
    step("mul_c2", O_MUL, 1);
    step("mul_c3", O_DONE, 1);
    drv(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0); step("mul_c4", O_NONE, 0);
    // mul_ex with an apparent load-use: multiply wins; mul_ex ignored while busy
    drv(0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0); step("mul_lu_c0", O_MUL, 1);
    drv(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0); step("mul_lu_c1", O_MUL, 0);
    step("mul_lu_c2", O_MUL, 0);
    drv(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0); step("mul_lu_c3", O_DONE, 0);
    drv(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0); step("mul_lu_c4", O_NONE, 0);
    // Reset during multiply cycle 1
    drv(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0); step("rst_mul_c0", O_MUL, 1);
    drv(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0); step("rst_mul_c1", O_NONE, 0);
    drv(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0); step("rst_after", O_NONE, 0);
    step("rst_after2", O_NONE, 0);
    drv(0, 1, 5'd7, 5'd0, 0, 5'd7, 1, 0, 0); step("lu_post_rst", O_LU, 0);
    drv(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0); step("final_idle", O_NONE, 0);
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
